// File: rtl/shared_bus_arbiter.sv
`default_nettype none
// ============================================================================
// shared_bus_arbiter : round-robin bus ownership with hold limit and turnaround
// Rev 1.0
// ============================================================================
module shared_bus_arbiter #(
  parameter int WIDTH    = 32,
  parameter int N        = 3,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_i,
  input  logic [N-1:0]         last_i,
  input  logic [N*WIDTH-1:0]   wdata_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] owner_o,
  output logic [WIDTH-1:0]     bus_o,
  output logic                 bus_valid_o,
  output logic                 timeout_o
);

  localparam int              OW        = $clog2(N);
  localparam int              HW        = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [OW-1:0]   IDX_MAX   = OW'(N - 1);
  localparam logic [OW:0]     N_WIDE    = (OW + 1)'(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [OW-1:0]  owner_q, owner_d;
  logic [OW-1:0]  ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           timeout_q, timeout_d;

  logic           any_req;
  logic [OW-1:0]  sel;
  logic [OW:0]    idx;
  logic           own_req;
  logic           own_last;
  logic [WIDTH-1:0] own_data;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (OW + 1)'(k);
      if (idx >= N_WIDE) begin
        idx = idx - N_WIDE;
      end
      if (req_i[idx[OW-1:0]]) begin
        any_req = 1'b1;
        sel     = idx[OW-1:0];
      end
    end
  end

  always_comb begin
    own_data = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == OW'(i)) begin
        own_data = wdata_i[i*WIDTH +: WIDTH];
      end
    end
  end

  assign own_req  = req_i[owner_q];
  assign own_last = last_i[owner_q];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;

    unique case (state_q)
      S_IDLE, S_TURN: begin
        if (any_req) begin
          state_d = S_OWN;
          gnt_d   = N'(1) << sel;
          owner_d = sel;
          ptr_d   = (sel == IDX_MAX) ? '0 : sel + OW'(1);
          hold_d  = '0;
        end else begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end
      end
      S_OWN: begin
        if (!own_req) begin
          state_d = S_TURN;
          gnt_d   = '0;
        end else begin
          hold_d = hold_q + HW'(1);
          if (own_last) begin
            state_d = S_TURN;
            gnt_d   = '0;
          end else if (hold_q == HOLD_LAST) begin
            // A coincident last beat takes the branch above, so no timeout then.
            state_d   = S_TURN;
            gnt_d     = '0;
            timeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign owner_o     = owner_q;
  assign timeout_o   = timeout_q;
  assign bus_o       = (state_q == S_OWN) ? own_data : '0;
  assign bus_valid_o = (state_q == S_OWN) & own_req;

endmodule
`default_nettype wire

// File: doc/shared_bus_arbiter.md
# shared_bus_arbiter

Round-robin ownership arbiter for a shared, multiply-aliased 32-bit bus: up to N requesters compete to drive a single net, and exactly one of them owns it at a time. The block grants ownership, muxes the owner's data onto the bus, and enforces a maximum hold time. It inserts a one-cycle turnaround between owners, with the bus undriven (zero), so that no two drivers ever overlap. It sits between the requesting submodules and the aliased bus net and is the only driver of that net.

## Interface
- WIDTH, 32, bus data width.
- N, 3, number of requesters (N ≥ 2).
- MAX_HOLD, 8, maximum beats per ownership tenure (≥ 1).
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req  input  N  per-requester ownership request; held high while the requester wants the bus.
- last  input  N  per-requester final-beat marker; only meaningful for the current owner.
- wdata  input  N*WIDTH  requester data; slice i is [i*WIDTH +: WIDTH].
- gnt  output  N  one-hot ownership grant, registered.
- owner  output  $clog2(N)  index of current/last owner, registered.
- bus  output  WIDTH  shared bus value: wdata[owner] while owning, else 0.
- bus_valid  output  1  beat transferred this cycle.
- timeout  output  1  one-cycle pulse on forced release.

## Operation
- States: IDLE, OWN, TURN. The state, grant, owner, pointer, hold counter and timeout are all registered.
- Arbitration function (used in IDLE and TURN): scan indices ptr, ptr+1, … (mod N) and select the first i with req[i]=1.
- IDLE, any req set: next cycle enter OWN with gnt = one-hot(sel), owner = sel, ptr = (sel+1) mod N, hold_cnt = 0.
- IDLE, no req set: stay in IDLE.
- OWN: bus = wdata[owner]; bus_valid = req[owner]. hold_cnt increments on every valid beat. Release to TURN next cycle when any of these hold:
  - (a) req[owner]=0 (abandon; no beat transferred, no timeout);
  - (b) req[owner]&last[owner] (final beat transferred);
  - (c) valid beat with hold_cnt == MAX_HOLD-1 (forced release).
- timeout: asserted in the TURN cycle following (c), only if last[owner]=0. When (b) and (c) coincide, last wins and timeout stays 0.
- TURN: gnt = 0, bus = 0, bus_valid = 0. Arbitrate as in IDLE: if any req is set, enter OWN next cycle; otherwise go to IDLE. The previous owner has lowest priority because ptr was already advanced at grant.
- In IDLE and TURN, bus = 0 and bus_valid = 0.
- last from non-owners is ignored. wdata from non-owners never reaches bus.
- Widths: hold_cnt is $clog2(MAX_HOLD+1) bits and never wraps, because it resets to 0 at each grant. The ptr wrap is explicit mod N, so for N=3 the value 3 is never stored.
- Reset (asynchronous assert, including mid-tenure): state=IDLE, gnt=0, owner=0, ptr=0, hold_cnt=0, timeout=0. bus and bus_valid go to 0 immediately, since they decode from state. The first arbitration after rst_n deasserts starts from index 0.

## Timing
- Grant latency: a req first seen high at edge t in IDLE/TURN gives gnt high from cycle t+1.
- bus and bus_valid are combinational from registered state/owner plus the live wdata/req inputs. Data is presented in the same cycle it is sampled.
- Tenure length: at most MAX_HOLD valid beats.
- Handover gap: exactly one TURN cycle between the last OWN cycle of one owner and the first OWN cycle of the next, when a requester is waiting.
- Two back-to-back TURN cycles never occur.
- gnt changes only on clock edges (or on reset); it never glitches combinationally.

## Test plan
- Single requester: req=001 from cycle 1, wdata0=32'hdeadbeef, last0 on the 3rd beat. Required response:
  - gnt=001 for cycles 2–4, bus=deadbeef with bus_valid=1 throughout;
  - cycle 5 TURN with gnt=0, bus=0;
  - cycle 6 IDLE.
- Full contention: req=111 constant, last=0, MAX_HOLD=8. Required response:
  - owners cycle 0→1→2→0, each for 8 valid beats, separated by single TURN cycles;
  - timeout pulses once per TURN.
- Fairness: owner 0 releases via last while req=101. The next gnt is 100 (index 2), not 001.
- Abandon: the owner drops req after 2 beats. Required response:
  - bus_valid=0 on the drop cycle;
  - TURN follows with timeout=0;
  - a waiting requester is granted one cycle later.
- last on the MAX_HOLD-th beat: release occurs with timeout=0, and the beat count equals 8.
- Async reset mid-OWN: rst_n low at any phase sends gnt/bus/bus_valid to 0 at once, without waiting for a clock edge. After release with req=010, gnt=010 one cycle later (ptr restarted at 0).
